// File: rtl/mips_pkg.sv
// mips_pkg: constants and types shared by the fetch, memory and decode stages
package mips_pkg;
   localparam int WORD_W = 32;
   localparam int INSTR_BYTES = 4;
   typedef logic [WORD_W-1:0] word_t;
   localparam word_t NOP_WORD = 32'h0000_0000;
endpackage

// File: rtl/if_id_register.sv
// if_id_register: IF/ID pipeline register with hold and bubble-injection control
import mips_pkg::*;
module if_id_register #(
   parameter word_t NOP = NOP_WORD
) (
   input  logic  clock,
   input  logic  reset,
   input  logic  hold,
   input  logic  bubble,
   input  word_t fetch_instruction,
   input  word_t fetch_pc,
   output word_t instruction,
   output word_t pc,
   output word_t pc_plus4,
   output logic  valid
);
   // Load the fetched word, or a NOP with valid low on a bubble; hold keeps everything
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         instruction <= NOP;
         pc          <= '0;
         pc_plus4    <= '0;
         valid       <= 1'b0;
      end else if (!hold) begin
         instruction <= bubble ? NOP : fetch_instruction;
         pc          <= fetch_pc;
         pc_plus4    <= fetch_pc + word_t'(INSTR_BYTES);
         valid       <= !bubble;
      end
   end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC register, next-PC selection and IF/ID capture for the MIPS front end
import mips_pkg::*;
module instruction_fetch_unit #(
   parameter word_t RESET_PC   = 32'h0000_0000,
   parameter word_t IMEM_LIMIT = 32'd64,
   parameter word_t NOP_WORD   = mips_pkg::NOP_WORD
) (
   input  logic  clock,
   input  logic  reset,
   input  logic  stall,
   input  logic  flush,
   input  logic  branch_taken,
   input  word_t branch_target,
   output word_t imem_addr,
   input  word_t imem_instruction,
   output word_t if_id_instruction,
   output word_t if_id_pc,
   output word_t if_id_pc_plus4,
   output logic  if_id_valid,
   output logic  halted,
   output word_t fetch_count
);
   word_t pc, pc_next;
   logic  squash, hold, bubble, load;
   assign imem_addr = pc;
   assign halted    = pc >= IMEM_LIMIT;
   assign squash    = flush | branch_taken;
   assign hold      = stall & ~squash;
   assign bubble    = squash | halted;
   assign load      = !hold && !bubble;
   // Redirect beats stall; stall and halt freeze the PC; otherwise advance one word
   always_comb begin
      pc_next = branch_taken ? (branch_target & ~word_t'(INSTR_BYTES - 1))
              : (stall || halted) ? pc
              : pc + word_t'(INSTR_BYTES);
   end
   // Program counter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) pc <= RESET_PC;
      else       pc <= pc_next;
   end
   // Count real instructions entering decode, saturating at all-ones
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                    fetch_count <= '0;
      else if (load && ~&fetch_count) fetch_count <= fetch_count + 1'b1;
   end
   if_id_register #(.NOP(NOP_WORD)) u_if_id (
      .clock             (clock),
      .reset             (reset),
      .hold              (hold),
      .bubble            (bubble),
      .fetch_instruction (imem_instruction),
      .fetch_pc          (pc),
      .instruction       (if_id_instruction),
      .pc                (if_id_pc),
      .pc_plus4          (if_id_pc_plus4),
      .valid             (if_id_valid)
   );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed checks of fetch, stall, flush, redirect, halt and async reset
module tb_instruction_fetch_unit;
   logic        clock = 0, reset = 1, stall = 0, flush = 0, branch_taken = 0;
   logic [31:0] branch_target = 0, imem_addr, imem_instruction;
   logic [31:0] if_id_instruction, if_id_pc, if_id_pc_plus4, fetch_count;
   logic        if_id_valid, halted;
   logic [31:0] mem [16];
   int          passed = 0, total = 0;

   instruction_fetch_unit dut (
      .clock(clock), .reset(reset), .stall(stall), .flush(flush),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_addr(imem_addr), .imem_instruction(imem_instruction),
      .if_id_instruction(if_id_instruction), .if_id_pc(if_id_pc),
      .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
      .halted(halted), .fetch_count(fetch_count)
   );

   always #5 clock = ~clock;
   // Combinational instruction memory; out-of-range reads return garbage
   assign imem_instruction = (imem_addr < 32'd64) ? mem[imem_addr[5:2]] : 32'hDEAD_BEEF;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                           input logic v, input logic [31:0] cnt, input logic [31:0] addr);
      chk({tag, ".instr"}, if_id_instruction, ins);
      chk({tag, ".pc"}, if_id_pc, pc);
      chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
      chk({tag, ".count"}, fetch_count, cnt);
      chk({tag, ".addr"}, imem_addr, addr);
   endtask

   task automatic chk_reset(input string tag);
      chk_ifid(tag, 32'h0, 32'h0, 1'b0, 32'd0, 32'h0);
      chk({tag, ".pc4"}, if_id_pc_plus4, 32'h0);
      chk({tag, ".halted"}, {31'd0, halted}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 | (i * 4);
      mem[0] = 32'h01098020;
      mem[1] = 32'h014B8822;
      mem[2] = 32'h02119020;
      #2;
      chk_reset("reset");
      #1 reset = 0;
      // sequential fetch
      step();
      chk_ifid("f0", 32'h01098020, 32'h0, 1'b1, 32'd1, 32'h4);
      chk("f0.pc4", if_id_pc_plus4, 32'h4);
      step();
      chk_ifid("f1", 32'h014B8822, 32'h4, 1'b1, 32'd2, 32'h8);
      // stall two cycles at pc=8
      stall = 1;
      step();
      chk_ifid("st1", 32'h014B8822, 32'h4, 1'b1, 32'd2, 32'h8);
      step();
      chk_ifid("st2", 32'h014B8822, 32'h4, 1'b1, 32'd2, 32'h8);
      stall = 0;
      step();
      chk_ifid("f2", 32'h02119020, 32'h8, 1'b1, 32'd3, 32'hC);
      chk("f2.pc4", if_id_pc_plus4, 32'hC);
      // redirect with unaligned target
      branch_taken = 1; branch_target = 32'h0000_0012;
      step();
      chk_ifid("br", 32'h0, 32'hC, 1'b0, 32'd3, 32'h10);
      branch_taken = 0;
      step();
      chk_ifid("br1", 32'h1000_0010, 32'h10, 1'b1, 32'd4, 32'h14);
      // redirect to 4, then flush+stall together
      branch_taken = 1; branch_target = 32'h4;
      step();
      branch_taken = 0; flush = 1; stall = 1;
      step();
      chk_ifid("fs", 32'h0, 32'h4, 1'b0, 32'd4, 32'h4);
      flush = 0; stall = 0;
      step();
      chk_ifid("fs1", 32'h014B8822, 32'h4, 1'b1, 32'd5, 32'h8);
      // run to the memory limit
      for (int n = 0; n < 20 && !halted; n++) step();
      chk("halt.flag", {31'd0, halted}, 32'd1);
      chk_ifid("halt", 32'h1000_003C, 32'h3C, 1'b1, 32'd19, 32'h40);
      step();
      chk_ifid("halt1", 32'h0, 32'h40, 1'b0, 32'd19, 32'h40);
      step();
      chk_ifid("halt2", 32'h0, 32'h40, 1'b0, 32'd19, 32'h40);
      branch_taken = 1; branch_target = 32'h0;
      step();
      chk("unhalt.flag", {31'd0, halted}, 32'd0);
      chk_ifid("unhalt", 32'h0, 32'h40, 1'b0, 32'd19, 32'h0);
      branch_taken = 0;
      step();
      chk_ifid("resume", 32'h01098020, 32'h0, 1'b1, 32'd20, 32'h4);
      step();
      step();
      chk_ifid("pre", 32'h02119020, 32'h8, 1'b1, 32'd22, 32'hC);
      // async reset mid-cycle during a stall at pc=12
      stall = 1;
      step();
      #2 reset = 1;
      #1 chk_reset("areset");
      #1 reset = 0; stall = 0;
      step();
      chk_ifid("restart", 32'h01098020, 32'h0, 1'b1, 32'd1, 32'h4);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
